// File: rtl/ft2232h_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// ft2232h_tx_arbiter_if
//   Signal bundle between two byte-stream requesters, the FT2232H transmit
//   pads and ft2232h_tx_arbiter.
//
//   req0_data_i / req0_valid_i / req0_ready_o : requester 0 byte stream
//   req1_data_i / req1_valid_i / req1_ready_o : requester 1 byte stream
//   txe_i   : FT2232H TXE#, active low, FIFO can accept a byte
//   data_o  : FT2232H data bus (registered)
//   wr_o    : FT2232H WR#, active low (registered)
//   busy_o  : arbiter busy (burst in progress or byte pending)
//   grant_o : channel of the current or last burst
//
//   slave  : the arbiter side
//   master : the requester / pad side
// ----------------------------------------------------------------------------
interface ft2232h_tx_arbiter_if;
    logic [7:0] req0_data_i;
    logic       req0_valid_i;
    logic       req0_ready_o;
    logic [7:0] req1_data_i;
    logic       req1_valid_i;
    logic       req1_ready_o;
    logic       txe_i;
    logic [7:0] data_o;
    logic       wr_o;
    logic       busy_o;
    logic       grant_o;

    modport slave (
        input  req0_data_i, req0_valid_i,
        input  req1_data_i, req1_valid_i,
        input  txe_i,
        output req0_ready_o, req1_ready_o,
        output data_o, wr_o, busy_o, grant_o
    );

    modport master (
        output req0_data_i, req0_valid_i,
        output req1_data_i, req1_valid_i,
        output txe_i,
        input  req0_ready_o, req1_ready_o,
        input  data_o, wr_o, busy_o, grant_o
    );
endinterface

// File: rtl/ft2232h_tx_arbiter.sv
// ----------------------------------------------------------------------------
// ft2232h_tx_arbiter
//   Shares the FT2232H synchronous-FIFO transmit path between two byte-stream
//   requesters. One requester is granted at a time, round-robin, for bursts
//   of up to MAX_BURST data bytes, each optionally preceded by a header byte
//   {4'hA, 3'b000, ch}. A single output holding register drives data_o and
//   WR#; WR# is low exactly while that register holds an unsent byte.
//
//   Parameters:
//     MAX_BURST : maximum data bytes per grant (1..255)
//     HDR_EN    : 1 = emit a header byte before each burst
//
//   Ports:
//     clkout_i : FT2232H CLKOUT (60 MHz), the only clock
//     rst_i    : asynchronous, active-high reset
//     bus      : requester streams, TXE#, data/WR# pads, busy and grant
// ----------------------------------------------------------------------------
module ft2232h_tx_arbiter #(
    parameter int unsigned MAX_BURST = 64,
    parameter bit          HDR_EN    = 1'b1
) (
    input  logic                 clkout_i,
    input  logic                 rst_i,
    ft2232h_tx_arbiter_if.slave  bus
);

    localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_data;
    logic       r_wr;
    logic       r_grant;
    logic       r_last;     // channel served by the most recent completed burst
    logic [7:0] r_cnt;

    logic       w_slot_free;
    logic       w_gnt_valid;
    logic [7:0] w_gnt_data;
    logic       w_take;
    logic [7:0] w_cnt_inc;
    logic       w_burst_end;
    logic       w_start;
    logic       w_pick;
    logic       w_load;
    logic [7:0] w_load_byte;
    logic       w_ready0;
    logic       w_ready1;

    // The holding register can take a new byte when it is empty, or when the
    // byte it holds is being accepted by the FIFO on this same edge.
    assign w_slot_free = r_wr | ~bus.txe_i;

    assign w_gnt_valid = r_grant ? bus.req1_valid_i : bus.req0_valid_i;
    assign w_gnt_data  = r_grant ? bus.req1_data_i  : bus.req0_data_i;

    assign w_take      = (r_state == S_DATA) && w_gnt_valid && w_slot_free;
    assign w_cnt_inc   = r_cnt + 8'd1;

    // Burst ends on reaching the byte limit, or on a stream gap seen while
    // the slot could have taken a byte.
    assign w_burst_end = (w_take && (w_cnt_inc == LP_MAX_BURST)) ||
                         ((r_state == S_DATA) && w_slot_free && !w_gnt_valid);

    assign w_start = (r_state == S_IDLE) && (bus.req0_valid_i || bus.req1_valid_i);

    // On a tie the channel not served last wins; otherwise the lone requester.
    assign w_pick  = (bus.req0_valid_i && bus.req1_valid_i) ? ~r_last
                                                            : bus.req1_valid_i;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clkout_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = HDR_EN ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                if (w_slot_free) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_burst_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load      = 1'b0;
        w_load_byte = r_data;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        unique case (r_state)
            S_HDR: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_byte = {4'hA, 3'b000, r_grant};
                end
            end
            S_DATA: begin
                w_ready0 = !r_grant && w_slot_free;
                w_ready1 =  r_grant && w_slot_free;
                if (w_take) begin
                    w_load      = 1'b1;
                    w_load_byte = w_gnt_data;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clkout_i or posedge rst_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_wr    <= 1'b1;
            r_grant <= 1'b0;
            r_last  <= 1'b1;    // ch0 wins the first tie
            r_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_grant <= w_pick;
                r_cnt   <= '0;
            end else if (w_take) begin
                r_cnt   <= w_cnt_inc;
            end

            if (w_burst_end) begin
                r_last <= r_grant;
            end

            // Load has priority: a load on an accepting edge keeps WR# low,
            // giving one byte per clock back-to-back.
            if (w_load) begin
                r_data <= w_load_byte;
                r_wr   <= 1'b0;
            end else if (!r_wr && !bus.txe_i) begin
                r_wr   <= 1'b1;
            end
        end
    end

    assign bus.data_o       = r_data;
    assign bus.wr_o         = r_wr;
    assign bus.grant_o      = r_grant;
    assign bus.busy_o       = (r_state != S_IDLE) || !r_wr;
    assign bus.req0_ready_o = w_ready0;
    assign bus.req1_ready_o = w_ready1;

endmodule

// File: doc/ft2232h_tx_arbiter.md
Name: ft2232h_tx_arbiter

Overview:
Shares the FT2232H synchronous-FIFO transmit path (PC-bound) between two byte-stream requesters. Grants one requester at a time in round-robin order for bursts of up to MAX_BURST bytes, each optionally prefixed by a channel header byte. Drives the FT2232H data bus and active-low WR# from a single output holding register, honouring TXE#. Sits between the capture/status logic and the FT2232H pads, in the clkout_i (60 MHz CLKOUT) domain.

Parameters:
MAX_BURST, 64, maximum data bytes per grant (1..255)
HDR_EN, 1, 1 = emit header byte {4'hA, 3'b000, ch} before each burst; 0 = no header

Ports:
clkout_i  input  1  FT2232H CLKOUT; the only clock
rst_i  input  1  asynchronous, active-high reset
req0_data_i  input  8  requester 0 byte
req0_valid_i  input  1  requester 0 byte valid
req0_ready_o  output  1  requester 0 byte taken this cycle when valid is also high
req1_data_i  input  8  requester 1 byte
req1_valid_i  input  1  requester 1 byte valid
req1_ready_o  output  1  requester 1 byte taken this cycle when valid is also high
txe_i  input  1  FT2232H TXE#, active low: FIFO can accept
data_o  output  8  FT2232H data bus (registered)
wr_o  output  1  FT2232H WR#, active low (registered)
busy_o  output  1  high while state != IDLE or the holding register is full
grant_o  output  1  channel of the current or last burst

Behaviour:
- Reset, asynchronous, checked on every edge: wr_o=1, data_o=8'h00, busy_o=0, grant_o=0, state=IDLE, burst count=0, round-robin pointer set so ch0 wins the first tie. A byte in the holding register is discarded.
- Holding register: wr_o=0 exactly when it holds an unsent byte. A byte is accepted at a posedge of clkout_i where wr_o==0 and txe_i==0.
- slot_free = (wr_o==1) || (txe_i==0). Combinational; a new byte may load on the same edge as acceptance, giving 1 byte/clk back-to-back.
- While txe_i==1: wr_o stays 0 and data_o stays stable until acceptance; nothing new loads.
- Requester rule: once valid is high it holds, with data stable, until valid&&ready. reqN_ready_o = (state==DATA) && (grant_o==N) && slot_free. It is combinational from txe_i and is never high for the non-granted channel.
- States:
  - IDLE: if either valid is high, grant. With both high, grant the channel not served last. Set grant_o and clear the burst count. Go to HDR if HDR_EN, else DATA. The first header or data byte loads no earlier than the next cycle.
  - HDR: when slot_free, load {4'hA,3'b000,grant_o} and go to DATA.
  - DATA: on valid&&ready, load the byte and increment the count. The burst ends and returns to IDLE when:
    - the count reaches MAX_BURST on this transfer, or
    - slot_free is high and the granted valid is low (stream gap).
    On burst end, update the round-robin pointer to grant_o.
- Bytes already in the holding register at burst end still complete while in IDLE. The next burst may be granted immediately; its first byte waits for slot_free.
- Burst count is 8 bits and never wraps; MAX_BURST caps it.
- Simultaneous events: txe_i rising on the same edge as a load is legal. The loaded byte simply waits.
- busy_o = (state!=IDLE) || (wr_o==0).

Test Plan:
- HDR_EN=1, ch0 sends 0x11,0x22 with txe_i=0 → data_o sequence 0xA0,0x11,0x22 with wr_o low for exactly 3 consecutive cycles, then wr_o=1, busy_o=0.
- MAX_BURST=4, ch1 holds valid continuously for 10 bytes 0x00..0x09, ch0 idle → header 0xA1 then 4 data bytes, then 0xA1 then 4 more, then 0xA1 then 2 more. No byte lost or duplicated.
- Both channels valid continuously, MAX_BURST=2 → headers alternate 0xA0,0xA1,0xA0,…, and ch0 is granted first after reset.
- txe_i held high for 5 cycles mid-burst after byte 0x33 loads → wr_o stays 0 and data_o stays 0x33 for all 5 cycles, ready stays low, and the byte is accepted once on the first edge with txe_i=0.
- rst_i pulsed asynchronously (not clock-aligned) mid-burst with wr_o=0 → wr_o=1 immediately, without waiting for a clock edge, and state=IDLE. After release, ch0 is granted first and a fresh header is emitted.
- HDR_EN=0, ch0 sends 0x55 then drops valid → only 0x55 on the bus, one wr_o low cycle, return to IDLE.
